// File: rtl/reset_pkg.sv
// Shared encodings and defaults for the reset release sequencer, common to
// every TMR leg and clock domain.
package reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2,
    SWRST   = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STRETCH_CYCLES = 16;
  localparam int DEF_SW_RST_CYCLES  = 8;
  localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/reset_release_seq_if.sv
// Control/status bundle between a domain's reset sequencer and its user.
interface reset_release_seq_if;
  logic porStatus;
  logic swRstReq;
  logic statusClr;
  logic rstOut;
  logic ready;
  logic causeHw;
  logic causeSw;
  logic porFault;
  logic clrAck;

  modport master (
    output porStatus, swRstReq, statusClr,
    input  rstOut, ready, causeHw, causeSw, porFault, clrAck
  );

  modport slave (
    input  porStatus, swRstReq, statusClr,
    output rstOut, ready, causeHw, causeSw, porFault, clrAck
  );
endinterface

// File: rtl/reset_sync_chain.sv
// Async-reset shift register used both as the reset-release synchronizer and
// as the porStatus level synchronizer.
module reset_sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= {STAGES{RST_VAL}};
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/reset_release_seq.sv
// Per-domain reset sequencer: async assert, synchronized and stretched release,
// software reset pulse, and sticky reset-cause / POR-fault status.
module reset_release_seq
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int SW_RST_CYCLES  = DEF_SW_RST_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst,
  reset_release_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SWRST_LOAD   = CNT_W'(SW_RST_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rel_sync;
  logic             por_sync;
  logic             rst_out_q;
  logic             ready_q;
  logic             cause_hw_q;
  logic             cause_sw_q;
  logic             por_fault_q;
  logic             clr_ack_q;
  logic             sw_accept;
  logic             por_detect;

  reset_sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rel_sync (
    .clk (clk),
    .rst (rst),
    .d   (1'b1),
    .q   (rel_sync)
  );

  reset_sync_chain #(.STAGES(2), .RST_VAL(1'b1)) u_por_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.porStatus),
    .q   (por_sync)
  );

  assign sw_accept  = (state == RUN) && bus.swRstReq;
  assign por_detect = (state == RUN) && por_sync;

  // HOLD spends one cycle observing the synchronized release, so STRETCH exits
  // on the edge its count reaches zero to keep release at SYNC+STRETCH edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      cnt         <= '0;
      rst_out_q   <= 1'b1;
      ready_q     <= 1'b0;
      cause_hw_q  <= 1'b1;
      cause_sw_q  <= 1'b0;
      por_fault_q <= 1'b0;
      clr_ack_q   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (rel_sync) begin
            if (STRETCH_CYCLES == 1) begin
              state     <= RUN;
              rst_out_q <= 1'b0;
              ready_q   <= 1'b1;
            end else begin
              state <= STRETCH;
              cnt   <= STRETCH_LOAD;
            end
          end
        end
        STRETCH: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            state     <= RUN;
            rst_out_q <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
        RUN: begin
          if (sw_accept) begin
            state     <= SWRST;
            cnt       <= SWRST_LOAD;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        SWRST: begin
          if (cnt == '0) begin
            state     <= RUN;
            rst_out_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= HOLD;
      endcase

      // Set events take priority over a simultaneous clear.
      if (sw_accept) begin
        cause_sw_q <= 1'b1;
        cause_hw_q <= 1'b0;
      end else if (bus.statusClr) begin
        cause_sw_q <= 1'b0;
        cause_hw_q <= 1'b0;
      end

      if (por_detect) begin
        por_fault_q <= 1'b1;
      end else if (bus.statusClr) begin
        por_fault_q <= 1'b0;
      end

      clr_ack_q <= bus.statusClr;
    end
  end

  assign bus.rstOut   = rst_out_q;
  assign bus.ready    = ready_q;
  assign bus.causeHw  = cause_hw_q;
  assign bus.causeSw  = cause_sw_q;
  assign bus.porFault = por_fault_q;
  assign bus.clrAck   = clr_ack_q;

endmodule

// File: tb/tb_reset_release_seq.sv
// Directed self-checking bench for reset_release_seq at default parameters.
module tb_reset_release_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  reset_release_seq_if bus ();

  reset_release_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.rstOut !== 1'b1) begin errors++; $display("[TB] FAIL reset_rstOut: got %b want 1", bus.rstOut); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", bus.ready); end
    checks++; if (bus.causeHw !== 1'b1) begin errors++; $display("[TB] FAIL reset_causeHw: got %b want 1", bus.causeHw); end
    checks++; if (bus.causeSw !== 1'b0) begin errors++; $display("[TB] FAIL reset_causeSw: got %b want 0", bus.causeSw); end
    checks++; if (bus.porFault !== 1'b0) begin errors++; $display("[TB] FAIL reset_porFault: got %b want 0", bus.porFault); end
    checks++; if (bus.clrAck !== 1'b0) begin errors++; $display("[TB] FAIL reset_clrAck: got %b want 0", bus.clrAck); end
    repeat (5) tick();
  endtask

  // Release with a swRstReq pulse during STRETCH that must be ignored.
  task automatic test_power_up();
    rst = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      bus.swRstReq = (i == 5);
      tick();
      checks++; if (bus.rstOut !== (i < 18)) begin errors++; $display("[TB] FAIL powerup_rstOut edge %0d: got %b want %b", i, bus.rstOut, (i < 18)); end
      checks++; if (bus.ready !== (i == 18)) begin errors++; $display("[TB] FAIL powerup_ready edge %0d: got %b want %b", i, bus.ready, (i == 18)); end
    end
    bus.swRstReq = 1'b0;
    checks++; if (bus.causeHw !== 1'b1) begin errors++; $display("[TB] FAIL powerup_causeHw: got %b want 1", bus.causeHw); end
    checks++; if (bus.causeSw !== 1'b0) begin errors++; $display("[TB] FAIL powerup_causeSw: got %b want 0", bus.causeSw); end
    tick();
    checks++; if (bus.rstOut !== 1'b0) begin errors++; $display("[TB] FAIL powerup_run_hold: got %b want 0", bus.rstOut); end
  endtask

  task automatic test_status_clear();
    bus.statusClr = 1'b1;
    tick();
    bus.statusClr = 1'b0;
    checks++; if (bus.causeHw !== 1'b0) begin errors++; $display("[TB] FAIL clear_causeHw: got %b want 0", bus.causeHw); end
    checks++; if (bus.clrAck !== 1'b1) begin errors++; $display("[TB] FAIL clear_ack_high: got %b want 1", bus.clrAck); end
    tick();
    checks++; if (bus.clrAck !== 1'b0) begin errors++; $display("[TB] FAIL clear_ack_low: got %b want 0", bus.clrAck); end
    checks++; if (bus.causeHw !== 1'b0) begin errors++; $display("[TB] FAIL clear_causeHw_sticky: got %b want 0", bus.causeHw); end
  endtask

  // Second request in the third SWRST cycle must not extend the pulse.
  task automatic test_sw_reset();
    bus.swRstReq = 1'b1;
    tick();
    checks++; if (bus.rstOut !== 1'b1) begin errors++; $display("[TB] FAIL swrst_rstOut_rise: got %b want 1", bus.rstOut); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL swrst_ready_fall: got %b want 0", bus.ready); end
    checks++; if (bus.causeSw !== 1'b1) begin errors++; $display("[TB] FAIL swrst_causeSw: got %b want 1", bus.causeSw); end
    checks++; if (bus.causeHw !== 1'b0) begin errors++; $display("[TB] FAIL swrst_causeHw: got %b want 0", bus.causeHw); end
    for (int k = 1; k <= 8; k++) begin
      bus.swRstReq = (k == 3);
      tick();
      checks++; if (bus.rstOut !== (k < 8)) begin errors++; $display("[TB] FAIL swrst_rstOut edge %0d: got %b want %b", k, bus.rstOut, (k < 8)); end
      checks++; if (bus.ready !== (k == 8)) begin errors++; $display("[TB] FAIL swrst_ready edge %0d: got %b want %b", k, bus.ready, (k == 8)); end
    end
    bus.swRstReq = 1'b0;
  endtask

  task automatic test_clear_with_sw();
    bus.statusClr = 1'b1;
    tick();
    checks++; if (bus.causeSw !== 1'b0) begin errors++; $display("[TB] FAIL clrsw_pre_causeSw: got %b want 0", bus.causeSw); end
    bus.swRstReq = 1'b1;
    tick();
    bus.swRstReq  = 1'b0;
    bus.statusClr = 1'b0;
    checks++; if (bus.causeSw !== 1'b1) begin errors++; $display("[TB] FAIL clrsw_causeSw: got %b want 1", bus.causeSw); end
    checks++; if (bus.clrAck !== 1'b1) begin errors++; $display("[TB] FAIL clrsw_clrAck: got %b want 1", bus.clrAck); end
    checks++; if (bus.rstOut !== 1'b1) begin errors++; $display("[TB] FAIL clrsw_rstOut: got %b want 1", bus.rstOut); end
    tick();
    checks++; if (bus.clrAck !== 1'b0) begin errors++; $display("[TB] FAIL clrsw_clrAck_low: got %b want 0", bus.clrAck); end
    checks++; if (bus.causeSw !== 1'b1) begin errors++; $display("[TB] FAIL clrsw_causeSw_sticky: got %b want 1", bus.causeSw); end
    repeat (7) tick();
    checks++; if (bus.rstOut !== 1'b0) begin errors++; $display("[TB] FAIL clrsw_run_rstOut: got %b want 0", bus.rstOut); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL clrsw_run_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_por_fault();
    bus.porStatus = 1'b1;
    tick();
    bus.porStatus = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      checks++; if (bus.porFault !== (e == 3)) begin errors++; $display("[TB] FAIL por_detect edge %0d: got %b want %b", e, bus.porFault, (e == 3)); end
      if (e < 3) tick();
    end
    repeat (5) tick();
    checks++; if (bus.porFault !== 1'b1) begin errors++; $display("[TB] FAIL por_sticky: got %b want 1", bus.porFault); end
    bus.statusClr = 1'b1;
    tick();
    bus.statusClr = 1'b0;
    checks++; if (bus.porFault !== 1'b0) begin errors++; $display("[TB] FAIL por_clear: got %b want 0", bus.porFault); end
    checks++; if (bus.clrAck !== 1'b1) begin errors++; $display("[TB] FAIL por_clrAck: got %b want 1", bus.clrAck); end
  endtask

  // Abort partway through STRETCH; porStatus pulsed in STRETCH must not flag.
  task automatic test_reset_mid_stretch();
    rst = 1'b1;
    #1;
    checks++; if (bus.rstOut !== 1'b1) begin errors++; $display("[TB] FAIL mid_async_rstOut: got %b want 1", bus.rstOut); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_ready: got %b want 0", bus.ready); end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++; if (bus.rstOut !== 1'b1) begin errors++; $display("[TB] FAIL mid_stretch_rstOut edge %0d: got %b want 1", i, bus.rstOut); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.rstOut !== 1'b1) begin errors++; $display("[TB] FAIL mid_abort_rstOut: got %b want 1", bus.rstOut); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_abort_ready: got %b want 0", bus.ready); end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      bus.porStatus = (i == 5 || i == 6);
      tick();
      checks++; if (bus.rstOut !== (i < 18)) begin errors++; $display("[TB] FAIL mid_release_rstOut edge %0d: got %b want %b", i, bus.rstOut, (i < 18)); end
    end
    bus.porStatus = 1'b0;
    repeat (3) tick();
    checks++; if (bus.porFault !== 1'b0) begin errors++; $display("[TB] FAIL mid_por_ignored: got %b want 0", bus.porFault); end
    checks++; if (bus.causeHw !== 1'b1) begin errors++; $display("[TB] FAIL mid_causeHw: got %b want 1", bus.causeHw); end
  endtask

  task automatic test_glitch();
    bus.statusClr = 1'b1;
    tick();
    bus.statusClr = 1'b0;
    checks++; if (bus.causeHw !== 1'b0) begin errors++; $display("[TB] FAIL glitch_pre_causeHw: got %b want 0", bus.causeHw); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.rstOut !== 1'b1) begin errors++; $display("[TB] FAIL glitch_async_rstOut: got %b want 1", bus.rstOut); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL glitch_async_ready: got %b want 0", bus.ready); end
    #2 rst = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      checks++; if (bus.rstOut !== (i < 18)) begin errors++; $display("[TB] FAIL glitch_release_rstOut edge %0d: got %b want %b", i, bus.rstOut, (i < 18)); end
      checks++; if (bus.ready !== (i == 18)) begin errors++; $display("[TB] FAIL glitch_release_ready edge %0d: got %b want %b", i, bus.ready, (i == 18)); end
    end
    checks++; if (bus.causeHw !== 1'b1) begin errors++; $display("[TB] FAIL glitch_causeHw: got %b want 1", bus.causeHw); end
    checks++; if (bus.causeSw !== 1'b0) begin errors++; $display("[TB] FAIL glitch_causeSw: got %b want 0", bus.causeSw); end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.porStatus = 1'b0;
    bus.swRstReq  = 1'b0;
    bus.statusClr = 1'b0;
    $display("[TB] starting reset_release_seq directed tests");
    test_reset();
    test_power_up();
    test_status_clear();
    test_sw_reset();
    test_clear_with_sw();
    test_por_fault();
    test_reset_mid_stretch();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
